// File: rtl/cra_pipe.sv
// cra_pipe: WIDTH-bit carry-ripple adder split into STAGES registered ripple segments, valid/ready at both ends.
// Define CRA_PIPE_OVF_EN to add the registered signed-overflow output ovf.

module cra_seg #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic c;
  always_comb begin
    s = '0;
    c = ci;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

module cra_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef CRA_PIPE_OVF_EN
 ,output logic             ovf
`endif
);
  localparam int SEG = WIDTH / STAGES;

  logic [STAGES-1:0] vld_pipe, vin, adv, load;

  // Advance ripples back from the consumer; an empty stage always loads.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = vld_pipe[STAGES-1] & out_ready;
    for (int k = STAGES-2; k >= 0; k--)
      adv[k] = vld_pipe[k] & (!vld_pipe[k+1] | adv[k+1]);
  end

  always_comb begin
    vin = '0;
    vin[0] = in_valid;
    for (int k = 1; k < STAGES; k++)
      vin[k] = vld_pipe[k-1];
  end

  assign load     = ~vld_pipe | adv;
  assign in_ready = load[0];

  always_ff @(posedge clk or posedge rst)
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= (vld_pipe & ~load) | (vin & load);

  for (genvar k = 0; k < STAGES; k++) begin : st
    localparam int LO = (k+1)*SEG;
    logic [SEG-1:0] sa, sb, ss;
    logic           si, so;
    logic [LO-1:0]  sum_d, sum_q;
    logic           c_q;

    if (k == 0) begin : g_src
      assign sa    = a[SEG-1:0];
      assign sb    = b[SEG-1:0];
      assign si    = cin;
      assign sum_d = ss;
    end else begin : g_src
      assign sa    = st[k-1].g_op.opa_q[SEG-1:0];
      assign sb    = st[k-1].g_op.opb_q[SEG-1:0];
      assign si    = st[k-1].c_q;
      assign sum_d = {ss, st[k-1].sum_q};
    end

    cra_seg #(.W(SEG)) u_seg (.a(sa), .b(sb), .ci(si), .s(ss), .co(so));

    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (load[k]) begin
        sum_q <= sum_d;
        c_q   <= so;
      end

    // Operand bits not yet consumed travel with the partial sum.
    if (k < STAGES-1) begin : g_op
      localparam int REM = WIDTH - LO;
      logic [REM-1:0] opa_d, opb_d, opa_q, opb_q;
      if (k == 0) begin : g_ld
        assign opa_d = a[WIDTH-1:SEG];
        assign opb_d = b[WIDTH-1:SEG];
      end else begin : g_ld
        assign opa_d = st[k-1].g_op.opa_q[WIDTH-k*SEG-1:SEG];
        assign opb_d = st[k-1].g_op.opb_q[WIDTH-k*SEG-1:SEG];
      end
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (load[k]) begin
          opa_q <= opa_d;
          opb_q <= opb_d;
        end
    end
  end

  assign out_valid = vld_pipe[STAGES-1];
  assign s         = st[STAGES-1].sum_q;
  assign cout      = st[STAGES-1].c_q;

`ifdef CRA_PIPE_OVF_EN
  // Carry into the MSB recovered as s^a^b of the top bit.
  logic cmsb, cmsb_q;
  assign cmsb = st[STAGES-1].sa[SEG-1] ^ st[STAGES-1].sb[SEG-1] ^ st[STAGES-1].ss[SEG-1];
  always_ff @(posedge clk or posedge rst)
    if (rst)                     cmsb_q <= 1'b0;
    else if (load[STAGES-1])     cmsb_q <= cmsb;
  assign ovf = cmsb_q ^ cout;
`endif
endmodule
